// File: rtl/voq_bank_if.sv
// Request/response bundle between the pointer allocator, the egress
// scheduler and voq_bank. The master side issues push/pop requests; the
// slave side (voq_bank) returns popped pointers and per-queue status.
interface voq_bank_if #(
   parameter int ADDR_W   = 12,
   parameter int N_QUEUES = 4,
   parameter int DEPTH    = 16
);
   localparam int QID_W = $clog2(N_QUEUES);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                      write_req_i;
   logic [QID_W-1:0]          write_qid_i;
   logic [ADDR_W-1:0]         ptr_i;
   logic                      read_req_i;
   logic [QID_W-1:0]          read_qid_i;
   logic [ADDR_W-1:0]         ptr_o;
   logic [QID_W-1:0]          ptr_qid_o;
   logic                      ptr_valid_o;
   logic [N_QUEUES-1:0]       empty_o;
   logic [N_QUEUES-1:0]       full_o;
   logic [N_QUEUES*CNT_W-1:0] count_o;
   logic [15:0]               drop_cnt_o;
   logic [CNT_W-1:0]          hwm_o;

   modport master (
      output write_req_i, write_qid_i, ptr_i, read_req_i, read_qid_i,
      input  ptr_o, ptr_qid_o, ptr_valid_o, empty_o, full_o, count_o,
             drop_cnt_o, hwm_o
   );

   modport slave (
      input  write_req_i, write_qid_i, ptr_i, read_req_i, read_qid_i,
      output ptr_o, ptr_qid_o, ptr_valid_o, empty_o, full_o, count_o,
             drop_cnt_o, hwm_o
   );
endinterface

// File: rtl/voq_bank.sv
// voq_bank: N_QUEUES independent circular pointer FIFOs, one per egress port.
// One push and one pop per cycle, each addressed by queue id. A push and pop
// to the same empty queue bypass storage straight to the registered output.
// Optional statistics (drop counter, occupancy high-water mark) are built
// only when VOQ_BANK_STATS_EN is defined; otherwise those outputs are 0.
module voq_bank #(
   parameter  int ADDR_W   = 12,
   parameter  int N_QUEUES = 4,
   parameter  int DEPTH    = 16,
   localparam int QID_W    = $clog2(N_QUEUES),
   localparam int CNT_W    = $clog2(DEPTH + 1),
   localparam int IDX_W    = $clog2(DEPTH),
   localparam int QSEL_N   = 1 << QID_W
) (
   input  logic       clk,
   input  logic       rst,
   voq_bank_if.slave  bus
);

   logic [ADDR_W-1:0] mem_q    [N_QUEUES][DEPTH];
   logic [IDX_W-1:0]  rd_idx_q [N_QUEUES];
   logic [IDX_W-1:0]  rd_idx_d [N_QUEUES];
   logic [IDX_W-1:0]  wr_idx_q [N_QUEUES];
   logic [IDX_W-1:0]  wr_idx_d [N_QUEUES];
   logic [CNT_W-1:0]  cnt_q    [N_QUEUES];
   logic [CNT_W-1:0]  cnt_d    [N_QUEUES];

   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [QID_W-1:0]  qid_q, qid_d;
   logic              valid_q, valid_d;

   logic [QSEL_N-1:0]   qid_legal;
   logic                wr_ok, rd_ok;
   logic [N_QUEUES-1:0] push_sel, pop_sel, store_en;
   logic                drop_ev;

   // Index wrap is explicit so DEPTH need not be a power of two.
   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
   endfunction

   // Queue ids beyond N_QUEUES-1 are treated as no request.
   always_comb begin
      for (int i = 0; i < QSEL_N; i++) begin
         qid_legal[i] = (i < N_QUEUES);
      end
   end

   assign wr_ok = bus.write_req_i & qid_legal[bus.write_qid_i];
   assign rd_ok = bus.read_req_i  & qid_legal[bus.read_qid_i];

   // One-hot decode of the push and pop targets.
   always_comb begin
      for (int q = 0; q < N_QUEUES; q++) begin
         push_sel[q] = wr_ok && (bus.write_qid_i == QID_W'(q));
         pop_sel[q]  = rd_ok && (bus.read_qid_i  == QID_W'(q));
      end
   end

   // Per-queue outcome: pop/bypass output selection, store, index and count updates.
   always_comb begin
      valid_d  = 1'b0;
      ptr_d    = ptr_q;
      qid_d    = qid_q;
      store_en = '0;
      drop_ev  = bus.write_req_i & ~wr_ok;
      for (int q = 0; q < N_QUEUES; q++) begin
         rd_idx_d[q] = rd_idx_q[q];
         wr_idx_d[q] = wr_idx_q[q];
         cnt_d[q]    = cnt_q[q];

         if (pop_sel[q] && (cnt_q[q] != '0)) begin
            valid_d     = 1'b1;
            ptr_d       = mem_q[q][rd_idx_q[q]];
            qid_d       = QID_W'(q);
            rd_idx_d[q] = idx_inc(rd_idx_q[q]);
         end else if (pop_sel[q] && push_sel[q]) begin
            valid_d = 1'b1;
            ptr_d   = bus.ptr_i;
            qid_d   = QID_W'(q);
         end

         // With a same-queue pop, a non-empty queue always has room (even when
         // full); an empty one was served by the bypass above.
         if (push_sel[q] && (pop_sel[q] ? (cnt_q[q] != '0)
                                         : (cnt_q[q] != CNT_W'(DEPTH)))) begin
            store_en[q] = 1'b1;
            wr_idx_d[q] = idx_inc(wr_idx_q[q]);
         end

         if (push_sel[q] && !pop_sel[q] && (cnt_q[q] == CNT_W'(DEPTH))) begin
            drop_ev = 1'b1;
         end

         if (store_en[q] && !(pop_sel[q] && (cnt_q[q] != '0))) begin
            cnt_d[q] = cnt_q[q] + 1'b1;
         end else if (!store_en[q] && pop_sel[q] && (cnt_q[q] != '0)) begin
            cnt_d[q] = cnt_q[q] - 1'b1;
         end
      end
   end

   // Control state and registered pop output; reset discards all contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int q = 0; q < N_QUEUES; q++) begin
            rd_idx_q[q] <= '0;
            wr_idx_q[q] <= '0;
            cnt_q[q]    <= '0;
         end
         ptr_q   <= '0;
         qid_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         for (int q = 0; q < N_QUEUES; q++) begin
            rd_idx_q[q] <= rd_idx_d[q];
            wr_idx_q[q] <= wr_idx_d[q];
            cnt_q[q]    <= cnt_d[q];
         end
         ptr_q   <= ptr_d;
         qid_q   <= qid_d;
         valid_q <= valid_d;
      end
   end

   // Pointer storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      for (int q = 0; q < N_QUEUES; q++) begin
         if (store_en[q]) begin
            mem_q[q][wr_idx_q[q]] <= bus.ptr_i;
         end
      end
   end

   // Status flags and packed occupancy, all from registered counts.
   always_comb begin
      bus.count_o = '0;
      for (int q = 0; q < N_QUEUES; q++) begin
         bus.empty_o[q]                   = (cnt_q[q] == '0);
         bus.full_o[q]                    = (cnt_q[q] == CNT_W'(DEPTH));
         bus.count_o[q*CNT_W +: CNT_W]    = cnt_q[q];
      end
   end

   assign bus.ptr_o       = ptr_q;
   assign bus.ptr_qid_o   = qid_q;
   assign bus.ptr_valid_o = valid_q;

`ifdef VOQ_BANK_STATS_EN
   logic [15:0]      drop_cnt_q;
   logic [CNT_W-1:0] hwm_q, hwm_d;

   // High-water mark follows the counts that become visible at the same edge.
   always_comb begin
      hwm_d = hwm_q;
      for (int q = 0; q < N_QUEUES; q++) begin
         if (cnt_d[q] > hwm_d) hwm_d = cnt_d[q];
      end
   end

   // Saturating drop counter and high-water mark registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt_q <= '0;
         hwm_q      <= '0;
      end else begin
         if (drop_ev && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
         hwm_q <= hwm_d;
      end
   end

   assign bus.drop_cnt_o = drop_cnt_q;
   assign bus.hwm_o      = hwm_q;
`else
   logic unused_drop_ev;
   assign unused_drop_ev = drop_ev;
   assign bus.drop_cnt_o = '0;
   assign bus.hwm_o      = '0;
`endif

endmodule

// File: tb/tb_voq_bank.sv
// Bench for voq_bank: queue-based reference model updated on each rising
// edge, a negedge compare process checking every output every cycle, and
// directed sequences with literal expectations followed by random traffic.
module tb_voq_bank;
   localparam int ADDR_W = 12;
   localparam int NQ     = 4;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 5;
`ifdef VOQ_BANK_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   voq_bank_if #(.ADDR_W(ADDR_W), .N_QUEUES(NQ), .DEPTH(DEPTH)) bus ();

   voq_bank #(.ADDR_W(ADDR_W), .N_QUEUES(NQ), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: one queue per VOQ.
   logic [ADDR_W-1:0] mq [NQ][$];
   logic [ADDR_W-1:0] e_ptr   = '0;
   int                e_qid   = 0;
   logic              e_valid = 1'b0;
   int                e_drop  = 0;
   int                e_hwm   = 0;
   int                m_rq, m_wq;
   bit                m_byp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int q = 0; q < NQ; q++) mq[q].delete();
         e_ptr = '0; e_qid = 0; e_valid = 1'b0; e_drop = 0; e_hwm = 0;
      end else begin
         m_byp   = 1'b0;
         e_valid = 1'b0;
         m_rq    = int'(bus.read_qid_i);
         m_wq    = int'(bus.write_qid_i);
         if (bus.read_req_i) begin
            if (mq[m_rq].size() > 0) begin
               e_ptr   = mq[m_rq].pop_front();
               e_qid   = m_rq;
               e_valid = 1'b1;
            end else if (bus.write_req_i && m_wq == m_rq) begin
               e_ptr   = bus.ptr_i;
               e_qid   = m_rq;
               e_valid = 1'b1;
               m_byp   = 1'b1;
            end
         end
         if (bus.write_req_i && !m_byp) begin
            if (mq[m_wq].size() < DEPTH) mq[m_wq].push_back(bus.ptr_i);
            else if (e_drop < 65535) e_drop++;
         end
         for (int q = 0; q < NQ; q++)
            if (mq[q].size() > e_hwm) e_hwm = mq[q].size();
      end
   end

   function automatic int cnt_of(input int q);
      return int'(bus.count_o[q*CNT_W +: CNT_W]);
   endfunction

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("valid", bus.ptr_valid_o, e_valid);
      chk("ptr",   bus.ptr_o, e_ptr);
      chk("qid",   bus.ptr_qid_o, e_qid);
      for (int q = 0; q < NQ; q++) begin
         chk($sformatf("count_q%0d", q), cnt_of(q), mq[q].size());
         chk($sformatf("empty_q%0d", q), bus.empty_o[q], mq[q].size() == 0);
         chk($sformatf("full_q%0d", q),  bus.full_o[q],  mq[q].size() == DEPTH);
      end
      chk("drop_cnt", bus.drop_cnt_o, STATS ? e_drop : 0);
      chk("hwm",      bus.hwm_o,      STATS ? e_hwm  : 0);
   end

   task automatic step(input bit w, input int wq, input int p, input bit r, input int rq);
      bus.write_req_i = w;
      bus.write_qid_i = 2'(wq);
      bus.ptr_i       = 12'(p);
      bus.read_req_i  = r;
      bus.read_qid_i  = 2'(rq);
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int q, input int p);
      step(1'b1, q, p, 1'b0, 0);
   endtask

   task automatic pop(input int q);
      step(1'b0, 0, 0, 1'b1, q);
   endtask

   task automatic chk_pop(input string name, input int ptr, input int qid);
      chk({name, "_valid"}, bus.ptr_valid_o, 1);
      chk({name, "_ptr"},   bus.ptr_o, ptr);
      chk({name, "_qid"},   bus.ptr_qid_o, qid);
   endtask

   initial begin
      bus.write_req_i = 1'b0; bus.write_qid_i = '0; bus.ptr_i = '0;
      bus.read_req_i  = 1'b0; bus.read_qid_i  = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_empty", bus.empty_o, 4'hF);
      chk("rst_full",  bus.full_o, 4'h0);
      chk("rst_valid", bus.ptr_valid_o, 0);
      chk("rst_ptr",   bus.ptr_o, 0);

      // 1: FIFO order on q1
      push(1, 'h010); push(1, 'h011); push(1, 'h012);
      chk("t1_count", cnt_of(1), 3);
      pop(1); chk_pop("t1_a", 'h010, 1);
      pop(1); chk_pop("t1_b", 'h011, 1);
      pop(1); chk_pop("t1_c", 'h012, 1);

      // 2: pop of empty queue
      pop(2);
      chk("t2_valid", bus.ptr_valid_o, 0);
      chk("t2_empty", bus.empty_o[2], 1);
      chk("t2_count", cnt_of(2), 0);
      chk("t2_ptr_hold", bus.ptr_o, 'h012);

      // 3: fill q0, drop on full, drain
      for (int i = 0; i < DEPTH; i++) push(0, 'h200 + i);
      chk("t3_full", bus.full_o[0], 1);
      push(0, 'hBAD);
      chk("t3_count", cnt_of(0), DEPTH);
      chk("t3_drop", bus.drop_cnt_o, STATS ? 1 : 0);
      for (int i = 0; i < DEPTH; i++) begin
         pop(0);
         chk_pop($sformatf("t3_drain%0d", i), 'h200 + i, 0);
      end
      chk("t3_empty", bus.empty_o[0], 1);

      // 4: bypass on empty q3, then same-cycle push+pop with content
      step(1'b1, 3, 'h0A0, 1'b1, 3);
      chk_pop("t4_byp", 'h0A0, 3);
      chk("t4_byp_count", cnt_of(3), 0);
      push(3, 'h0A0); push(3, 'h0A1);
      step(1'b1, 3, 'h0B0, 1'b1, 3);
      chk_pop("t4_pp", 'h0A0, 3);
      chk("t4_pp_count", cnt_of(3), 2);
      pop(3); chk_pop("t4_a", 'h0A1, 3);
      pop(3); chk_pop("t4_b", 'h0B0, 3);

      // 5: push+pop on full q1
      for (int i = 0; i < DEPTH; i++) push(1, 'h300 + i);
      step(1'b1, 1, 'h3FF, 1'b1, 1);
      chk_pop("t5_pp", 'h300, 1);
      chk("t5_count", cnt_of(1), DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         pop(1);
         chk_pop($sformatf("t5_drain%0d", i), (i < DEPTH - 1) ? 'h301 + i : 'h3FF, 1);
      end

      // 6: interleave across queues
      push(0, 'h100); push(1, 'h101);
      step(1'b1, 0, 'h102, 1'b1, 1);
      chk_pop("t6_q1", 'h101, 1);
      pop(0); chk_pop("t6_a", 'h100, 0);
      pop(0); chk_pop("t6_b", 'h102, 0);
      chk("t6_hwm", bus.hwm_o, STATS ? DEPTH : 0);

      // Random traffic: filling phase then draining phase
      for (int i = 0; i < 3000; i++) begin
         int wp, rp;
         wp = (i < 1500) ? 70 : 30;
         rp = (i < 1500) ? 40 : 70;
         step($urandom_range(99) < wp, $urandom_range(3), $urandom_range(4095),
              $urandom_range(99) < rp, $urandom_range(3));
      end

      // Reset mid-stream, with traffic still being requested
      for (int q = 0; q < NQ; q++) push(q, 'h7A0 + q);
      bus.read_req_i = 1'b1; bus.read_qid_i = 2'd0; bus.write_req_i = 1'b1;
      rst = 1'b1;
      #1;
      chk("mrst_empty", bus.empty_o, 4'hF);
      chk("mrst_count0", cnt_of(0), 0);
      chk("mrst_valid", bus.ptr_valid_o, 0);
      @(posedge clk); #1;
      chk("mrst_valid2", bus.ptr_valid_o, 0);
      bus.read_req_i = 1'b0; bus.write_req_i = 1'b0;
      rst = 1'b0;
      step(1'b0, 0, 0, 1'b0, 0);
      chk("post_rst_valid", bus.ptr_valid_o, 0);
      chk("post_rst_empty", bus.empty_o, 4'hF);
      chk("post_rst_drop", bus.drop_cnt_o, 0);
      push(2, 'h055);
      pop(2); chk_pop("post_rst", 'h055, 2);
      step(1'b0, 0, 0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
